// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for a loadable up/down counter: N sweeps lo->hi->lo, then a done pulse.
// Optional count-feedback checker enabled by defining CNT_SEQ_CHECK_EN.
module counter_sweep_ctrl #(
  parameter int WIDTH   = 3,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic [WIDTH-1:0]   count,
  output logic               load,
  output logic [WIDTH-1:0]   data_out,
  output logic               count_up,
  output logic               counter_on,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               mismatch
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_UP   = 3'd2;
  localparam logic [2:0] S_DOWN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] n_q, n_d;
  logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic               cfg_err_q, cfg_err_d;
  logic [SWEEP_W-1:0] sweep_inc;
  logic               cfg_bad;
  logic               accept;

  assign sweep_inc = sweep_cnt_q + SWEEP_W'(1);
  assign cfg_bad   = (lo_lim >= hi_lim) || (n_sweeps == '0);
  assign accept    = (state_q == S_IDLE) && start && !cfg_bad;

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    n_d         = n_q;
    sweep_cnt_d = sweep_cnt_q;
    cfg_err_d   = 1'b0;
    load        = 1'b0;
    counter_on  = 1'b0;
    count_up    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && cfg_bad) begin
          cfg_err_d = 1'b1;
        end else if (accept) begin
          lo_d        = lo_lim;
          hi_d        = hi_lim;
          n_d         = n_sweeps;
          sweep_cnt_d = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = abort ? S_IDLE : S_UP;
      end
      S_UP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_UP;
        end else if (count == hi_q) begin
          // Turnaround dwell: counter idles one cycle at the top.
          state_d = S_DOWN;
        end else begin
          counter_on = 1'b1;
          count_up   = 1'b1;
        end
      end
      S_DOWN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_DOWN;
        end else if (count == lo_q) begin
          sweep_cnt_d = sweep_inc;
          state_d     = (sweep_inc == n_q) ? S_DONE : S_UP;
        end else begin
          counter_on = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      n_q         <= '0;
      sweep_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      n_q         <= n_d;
      sweep_cnt_q <= sweep_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign data_out  = lo_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DOWN);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;
  assign sweep_cnt = sweep_cnt_q;

`ifdef CNT_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             mismatch_q, mismatch_d;

  // Shadow of the counter: seeded by LOAD, stepped by every enabled cycle.
  always_comb begin
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    if (accept) begin
      mismatch_d = 1'b0;
    end
    if (state_q == S_LOAD) begin
      exp_d = lo_q;
    end
    if ((state_q == S_UP) || (state_q == S_DOWN)) begin
      if (count != exp_q) begin
        mismatch_d = 1'b1;
      end
      if (counter_on) begin
        exp_d = count_up ? exp_q + WIDTH'(1) : exp_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Randomized bench for counter_sweep_ctrl with a behavioural counter and a trace-based sweep model.
module tb_counter_sweep_ctrl;
  localparam int WIDTH   = 3;
  localparam int SWEEP_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start, abort, pause;
  logic [WIDTH-1:0]   lo_lim, hi_lim, count;
  logic [SWEEP_W-1:0] n_sweeps;
  logic               load, count_up, counter_on, busy, done, cfg_err, mismatch;
  logic [WIDTH-1:0]   data_out;
  logic [SWEEP_W-1:0] sweep_cnt;
  bit                 skip_once = 1'b0;

  counter_sweep_ctrl #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .n_sweeps(n_sweeps), .count(count),
    .load(load), .data_out(data_out), .count_up(count_up), .counter_on(counter_on),
    .busy(busy), .done(done), .cfg_err(cfg_err), .sweep_cnt(sweep_cnt), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // The controlled counter: reset > load > counter_on. skip_once injects a +2 step.
  always @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (load) count <= data_out;
    else if (counter_on) begin
      if (count_up) count <= count + (skip_once ? 3'd2 : 3'd1);
      else count <= count - 3'd1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  typedef struct {
    bit ld, on, up, dn;
    int cnt, sw;
  } step_t;

  step_t trace[$];
  int    cur_lo = 0;
  int    last_sw = 0;
  int    exp_mm = 0;

  // Expected cycle-by-cycle trace of an uninterrupted run, straight from the sweep rules.
  task automatic build_trace(input int lo, input int hi, input int n);
    step_t e;
    trace.delete();
    e = '{ld: 1, on: 0, up: 0, dn: 0, cnt: 0, sw: 0};
    trace.push_back(e);
    for (int s = 0; s < n; s++) begin
      for (int c = lo; c < hi; c++) begin
        e = '{ld: 0, on: 1, up: 1, dn: 0, cnt: c, sw: s};
        trace.push_back(e);
      end
      e = '{ld: 0, on: 0, up: 0, dn: 0, cnt: hi, sw: s};
      trace.push_back(e);
      for (int c = hi; c > lo; c--) begin
        e = '{ld: 0, on: 1, up: 0, dn: 0, cnt: c, sw: s};
        trace.push_back(e);
      end
      e = '{ld: 0, on: 0, up: 0, dn: 0, cnt: lo, sw: s};
      trace.push_back(e);
    end
    e = '{ld: 0, on: 0, up: 0, dn: 1, cnt: lo, sw: n};
    trace.push_back(e);
  endtask

  task automatic check_idle(input int cfg_exp);
    chk("idle_busy", busy, 0);
    chk("idle_load", load, 0);
    chk("idle_on", counter_on, 0);
    chk("idle_up", count_up, 0);
    chk("idle_done", done, 0);
    chk("idle_cfg_err", cfg_err, cfg_exp);
    chk("idle_sweep_cnt", sweep_cnt, last_sw);
    chk("idle_data_out", data_out, cur_lo);
    chk("idle_mismatch", mismatch, exp_mm);
  endtask

  task automatic run_illegal(input int lo, input int hi, input int n);
    @(negedge clk);
    lo_lim = lo; hi_lim = hi; n_sweeps = n; start = 1; abort = 0; pause = 0;
    #1 check_idle(0);
    @(negedge clk);
    start = 0;
    #1 check_idle(1);
    $display("illegal lo=%0d hi=%0d n=%0d cfg_err=%0d busy=%0d", lo, hi, n, cfg_err, busy);
  endtask

  task automatic run_legal(input int lo, input int hi, input int n, input bit p_en, input bit a_en);
    int    idx = 0;
    bit    fin = 0;
    bit    aborted = 0;
    int    cycles = 0;
    step_t e;
    @(negedge clk);
    lo_lim = lo; hi_lim = hi; n_sweeps = n; start = 1; abort = 0; pause = 0;
    #1 check_idle(0);
    build_trace(lo, hi, n);
    cur_lo = lo;
    exp_mm = 0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 7) == 0);
      lo_lim   = $urandom; hi_lim = $urandom; n_sweeps = $urandom;
      pause    = p_en && ($urandom_range(0, 5) == 0);
      abort    = a_en && ($urandom_range(0, 40) == 0);
      #1;
      cycles++;
      e = trace[idx];
      chk("data_out", data_out, cur_lo);
      chk("cfg_err", cfg_err, 0);
      chk("mismatch", mismatch, exp_mm);
      if (abort && !e.dn) begin
        chk("abort_busy", busy, 1);
        chk("abort_load", load, e.ld);
        chk("abort_on", counter_on, 0);
        chk("abort_done", done, 0);
        chk("abort_sw", sweep_cnt, e.sw);
        last_sw = e.sw; fin = 1; aborted = 1;
      end else if (pause && !e.ld && !e.dn) begin
        chk("pause_busy", busy, 1);
        chk("pause_on", counter_on, 0);
        chk("pause_up", count_up, 0);
        chk("pause_sw", sweep_cnt, e.sw);
        chk("pause_count", count, e.cnt);
      end else begin
        chk("busy", busy, !e.dn);
        chk("load", load, e.ld);
        chk("counter_on", counter_on, e.on);
        chk("count_up", count_up, e.up);
        chk("done", done, e.dn);
        chk("sweep_cnt", sweep_cnt, e.sw);
        if (!e.ld) chk("count", count, e.cnt);
        idx++;
        if (e.dn) begin last_sw = e.sw; fin = 1; end
      end
    end
    chk("run_finished", fin, 1);
    @(negedge clk);
    start = 0; pause = $urandom; abort = $urandom;
    #1 check_idle(0);
    $display("run lo=%0d hi=%0d n=%0d cycles=%0d aborted=%0d sweep_cnt=%0d", lo, hi, n, cycles, aborted, sweep_cnt);
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; pause = 0;
    lo_lim = 0; hi_lim = 0; n_sweeps = 0;
    #1 check_idle(0);
    repeat (2) @(negedge clk);
    reset = 0;
    #1 check_idle(0);

    run_legal(1, 3, 1, 0, 0);
    run_legal(0, 7, 3, 0, 0);
    run_illegal(5, 5, 3);
    run_illegal(2, 6, 0);
    run_illegal(6, 2, 1);
    run_legal(2, 5, 2, 1, 0);
    run_legal(0, 6, 4, 1, 1);

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    lo_lim = 2; hi_lim = 6; n_sweeps = 2; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_on", counter_on, 0);
    chk("rst_up", count_up, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_sweep_cnt", sweep_cnt, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_mismatch", mismatch, 0);
    $display("reset mid-run busy=%0d sweep_cnt=%0d", busy, sweep_cnt);
    cur_lo = 0; last_sw = 0; exp_mm = 0;
    @(negedge clk);
    reset = 0;
    run_legal(3, 7, 2, 0, 0);

    for (int r = 0; r < 25; r++) begin
      int lo, hi, n;
      lo = $urandom_range(0, 7); hi = $urandom_range(0, 7); n = $urandom_range(0, 4);
      if (lo >= hi || n == 0) run_illegal(lo, hi, n);
      else run_legal(lo, hi, n, 1, 1);
    end

`ifdef CNT_SEQ_CHECK_EN
    begin
      bit seen;
      @(negedge clk);
      lo_lim = 0; hi_lim = 7; n_sweeps = 1; start = 1; abort = 0; pause = 0;
      @(negedge clk);
      start = 0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        #1;
        if (count == 3'd2 && counter_on) seen = 1;
      end
      chk("skip_reached", seen, 1);
      skip_once = 1;
      @(negedge clk);
      skip_once = 0;
      #1 chk("mm_pre", mismatch, 0);
      @(negedge clk);
      #1 chk("mm_set", mismatch, 1);
      seen = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
        @(negedge clk);
        #1;
        if (done) seen = 1;
      end
      chk("mm_run_done", seen, 1);
      @(negedge clk);
      #1 chk("mm_sticky", mismatch, 1);
      $display("skip injected mismatch=%0d", mismatch);
      last_sw = 1; cur_lo = 0; exp_mm = 1;
      run_legal(1, 4, 1, 0, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for a loadable 3-bit up/down counter. The counter has inputs load, count_up and counter_on, a Data_in bus, and a Count output. It has async active-high reset, and priority order reset > load > counter_on.
- This block drives the counter's control pins and observes Count. It performs N triangle sweeps lo→hi→lo, then signals completion.
- It sits between the host/config logic and the counter instance.

Parameters:
- WIDTH, 3, counter data width.
- SWEEP_W, 4, width of the sweep-count field.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request a sweep run; sampled only in IDLE.
- abort  input  1  terminate the current run; checked in LOAD, UP and DOWN.
- pause  input  1  freeze counting in UP/DOWN; state is held.
- lo_lim  input  WIDTH  lower sweep bound, captured at start.
- hi_lim  input  WIDTH  upper sweep bound, captured at start.
- n_sweeps  input  SWEEP_W  number of sweeps, captured at start.
- count  input  WIDTH  Count fed back from the counter.
- load  output  1  to counter load.
- data_out  output  WIDTH  to counter Data_in.
- count_up  output  1  to counter count_up.
- counter_on  output  1  to counter counter_on.
- busy  output  1  high in LOAD/UP/DOWN.
- done  output  1  one-cycle pulse on run completion.
- cfg_err  output  1  one-cycle pulse on illegal config at start.
- sweep_cnt  output  SWEEP_W  sweeps completed in the current run.
- mismatch  output  1  sticky counter-behaviour fault flag (see Optional Feature).

Behaviour:
- Reset (async):
  - state = IDLE.
  - lo_r, hi_r, n_r and sweep_cnt = 0.
  - All outputs = 0.
  - Reset mid-run returns to IDLE immediately, with no done pulse.
- Control outputs are combinational decodes of state, registered config and count. The count input is registered in the counter, so there is no combinational loop. data_out = lo_r at all times.
- IDLE:
  - If start = 1 and (lo_lim >= hi_lim or n_sweeps == 0): pulse cfg_err for one cycle, stay in IDLE, do not capture config.
  - Else if start = 1: capture lo_r, hi_r and n_r; clear sweep_cnt; go to LOAD.
- LOAD:
  - load = 1.
  - Next state is UP, or IDLE if abort = 1 (load is still asserted this cycle).
- UP:
  - abort = 1 → IDLE, counter_on = 0.
  - Else pause = 1 → counter_on = 0, hold state.
  - Else count == hi_r → counter_on = 0, go to DOWN (one-cycle turnaround dwell).
  - Else counter_on = 1, count_up = 1.
- DOWN:
  - abort = 1 → IDLE.
  - Else pause = 1 → hold state.
  - Else count == lo_r → counter_on = 0, sweep_cnt += 1. Go to DONE if sweep_cnt+1 == n_r, else go to UP.
  - Else counter_on = 1, count_up = 0.
- DONE:
  - done = 1 for one cycle, then IDLE.
  - sweep_cnt holds its final value until the next accepted start.
- start while busy is ignored. Abort takes priority over pause. The counter is never driven past hi_r or below lo_r, so it never wraps.
- Latency with no pause: start sampled at edge 0 → done high in cycle 1 + n·(2·(hi−lo)+2) + 1.
- Config inputs may change freely while busy; only the captured copies are used.

Optional Feature:
- Macro: CNT_SEQ_CHECK_EN.
- Defined: the block tracks the expected count.
  - Expected count is set to lo_r after LOAD.
  - It is ±1 after each cycle with counter_on = 1, and unchanged otherwise.
  - From the cycle after LOAD until return to IDLE, mismatch is set sticky if count ≠ expected in any UP/DOWN cycle.
  - mismatch clears only on reset or on an accepted start.
  - Sequencing is unaffected.
- Not defined: mismatch is tied to 0 and no tracking logic is present.

Test Plan:
- Basic run: lo=1, hi=3, n=1, start at cycle 0 → load in cycle 1; counter_on up in cycles 2–3; dwell at 3 in cycle 4; counter_on down in cycles 5–6; dwell at 1 in cycle 7; done in cycle 8; sweep_cnt = 1; busy low from cycle 8.
- Multi-sweep: lo=0, hi=7, n=3 → done at cycle 1 + 3·16 + 1 = 50; count sequence 0..7..0 repeated 3 times; sweep_cnt ends at 3.
- Illegal config: lo=5, hi=5 or n=0 with start → cfg_err pulses for one cycle; state stays IDLE; load never asserted.
- Pause/abort: pause high for 4 cycles mid-UP → count frozen, done delayed by 4 cycles. abort in DOWN → counter_on = 0 that cycle, IDLE next cycle, no done pulse.
- Reset mid-run: assert reset asynchronously during UP → all outputs 0 immediately; a subsequent start with a new config runs cleanly.
- CNT_SEQ_CHECK_EN: force the count feedback to skip a value during UP → mismatch goes high the next cycle and stays high until the next start. Without the macro, mismatch stays 0.
